// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit 7-segment driver for two
// 4-digit groups with shared active-high anodes. It snapshots the input
// frame once per scan frame, blanks the anodes at the start of each slot,
// and gates blinking digits from a slow phase toggle.
//
// Digit code encoding (5 bits): 5'h00..5'h0F = hex 0..F, 5'h10 = H,
// 5'h1F = blank. Any other value decodes to all segments off.

// seg_decode: one digit code to {dp,g,f,e,d,c,b,a}, active-high.
module seg_decode (
  input  logic [4:0] code,
  output logic [7:0] seg
);
  // Pure lookup; unknown codes fall through to blank.
  always_comb begin
    case (code)
      5'h00:   seg = 8'h3F;
      5'h01:   seg = 8'h06;
      5'h02:   seg = 8'h5B;
      5'h03:   seg = 8'h4F;
      5'h04:   seg = 8'h66;
      5'h05:   seg = 8'h6D;
      5'h06:   seg = 8'h7D;
      5'h07:   seg = 8'h07;
      5'h08:   seg = 8'h7F;
      5'h09:   seg = 8'h6F;
      5'h0A:   seg = 8'h77;
      5'h0B:   seg = 8'h7C;
      5'h0C:   seg = 8'h39;
      5'h0D:   seg = 8'h5E;
      5'h0E:   seg = 8'h79;
      5'h0F:   seg = 8'h71;
      5'h10:   seg = 8'h76;
      5'h1F:   seg = 8'h00;
      default: seg = 8'h00;
    endcase
  end
endmodule

module seg_scan_driver #(
  parameter int SCAN_DIV    = 100_000,
  parameter int DEAD_CYCLES = 1_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            disp_en,
  input  logic [7:0][4:0] seg_data_in,
  input  logic [7:0]      seg_blink_in,
  output logic [7:0]      an,
  output logic [7:0]      seg_hi,
  output logic [7:0]      seg_lo,
  output logic            frame_tick
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEAD_END  = DW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [4:0]    CHAR_BLK  = 5'h1F;

  logic [DW-1:0]      div_cnt;
  logic [1:0]         slot;
  logic [BW-1:0]      blink_cnt;
  logic               blink_phase;
  logic [7:0][4:0]    snap_data;
  logic [7:0]         snap_blink;
  logic [7:0][7:0]    dec;

  logic               div_wrap, frame_wrap, lit;
  logic [2:0]         hi_idx, lo_idx;
  logic [7:0]         an_nxt, hi_nxt, lo_nxt;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign frame_wrap = div_wrap && (slot == 2'd3);

  // Slot k shows digit 3-k (lo) and 7-k (hi); 3-k on two bits is ~k.
  assign lo_idx = {1'b0, ~slot};
  assign hi_idx = {1'b1, ~slot};
  assign lit    = disp_en && (div_cnt >= DEAD_END);

  // Decode every snapshot digit; the scan mux picks two of them.
  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg_decode u_dec (.code(snap_data[g]), .seg(dec[g]));
  end

  // Next pin values from current counter state; registered below.
  always_comb begin
    an_nxt = 8'h00;
    hi_nxt = 8'h00;
    lo_nxt = 8'h00;
    if (lit) begin
      an_nxt = (8'd1 << hi_idx) | (8'd1 << lo_idx);
      if (!(blink_phase && snap_blink[hi_idx])) hi_nxt = dec[hi_idx];
      if (!(blink_phase && snap_blink[lo_idx])) lo_nxt = dec[lo_idx];
    end
  end

  // Slot divider and slot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= 2'd0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      slot    <= slot + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Blink divider; phase flips on each wrap, independent of the scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Frame snapshot: inputs only sampled when entering slot 0, so a frame
  // never mixes old and new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_data  <= {8{CHAR_BLK}};
      snap_blink <= 8'h00;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (frame_wrap) begin
        snap_data  <= seg_data_in;
        snap_blink <= seg_blink_in;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an     <= 8'h00;
      seg_hi <= 8'h00;
      seg_lo <= 8'h00;
    end else begin
      an     <= an_nxt;
      seg_hi <= hi_nxt;
      seg_lo <= lo_nxt;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with small dividers. A cycle-number based
// reference model predicts every pin each cycle; scenario tasks add
// targeted checks on top.
module tb_seg_scan_driver;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BD = 64;
  localparam int FR = 4 * SD;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] hi;
    logic [7:0] lo;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            disp_en = 1'b1;
  logic [7:0][4:0] seg_data_in = {8{5'h1F}};
  logic [7:0]      seg_blink_in = 8'h00;
  logic [7:0]      an, seg_hi, seg_lo;
  logic            frame_tick;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  seg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .disp_en(disp_en), .seg_data_in(seg_data_in),
    .seg_blink_in(seg_blink_in), .an(an), .seg_hi(seg_hi), .seg_lo(seg_lo),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_seg [32];
  initial begin
    for (int i = 0; i < 32; i++) ref_seg[i] = 8'h00;
    ref_seg[0]  = 8'h3F; ref_seg[1]  = 8'h06; ref_seg[2]  = 8'h5B; ref_seg[3]  = 8'h4F;
    ref_seg[4]  = 8'h66; ref_seg[5]  = 8'h6D; ref_seg[6]  = 8'h7D; ref_seg[7]  = 8'h07;
    ref_seg[8]  = 8'h7F; ref_seg[9]  = 8'h6F; ref_seg[10] = 8'h77; ref_seg[11] = 8'h7C;
    ref_seg[12] = 8'h39; ref_seg[13] = 8'h5E; ref_seg[14] = 8'h79; ref_seg[15] = 8'h71;
    ref_seg[16] = 8'h76;
  end

  // Expected pins for the cycle numbered c since reset release.
  function automatic exp_t model(int c, logic [7:0][4:0] sd, logic [7:0] sb, logic en);
    exp_t e;
    int div, sl, ph, hd, ld;
    e   = '0;
    div = c % SD;
    sl  = (c / SD) % 4;
    ph  = (c / BD) % 2;
    hd  = 7 - sl;
    ld  = 3 - sl;
    if (en && div >= DC) begin
      e.an = 8'((1 << hd) | (1 << ld));
      e.hi = (ph == 1 && sb[hd]) ? 8'h00 : ref_seg[sd[hd]];
      e.lo = (ph == 1 && sb[ld]) ? 8'h00 : ref_seg[sd[ld]];
    end
    return e;
  endfunction

  int              cyc;
  logic [7:0][4:0] m_snap;
  logic [7:0]      m_blink;
  exp_t            m_exp;
  logic            m_ft;

  // Reference model state, advanced once per clock.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc     <= 0;
      m_snap  <= {8{5'h1F}};
      m_blink <= 8'h00;
      m_exp   <= '0;
      m_ft    <= 1'b0;
    end else begin
      m_exp <= model(cyc, m_snap, m_blink, disp_en);
      m_ft  <= (cyc % FR == FR - 1);
      if (cyc % FR == FR - 1) begin
        m_snap  <= seg_data_in;
        m_blink <= seg_blink_in;
      end
      cyc <= cyc + 1;
    end
  end

  // Continuous comparison of all pins against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      checks += 4;
      if (an !== m_exp.an) begin
        errors++; $display("FAIL mon_an cyc=%0d got=%h exp=%h", cyc, an, m_exp.an);
      end
      if (seg_hi !== m_exp.hi) begin
        errors++; $display("FAIL mon_seg_hi cyc=%0d got=%h exp=%h", cyc, seg_hi, m_exp.hi);
      end
      if (seg_lo !== m_exp.lo) begin
        errors++; $display("FAIL mon_seg_lo cyc=%0d got=%h exp=%h", cyc, seg_lo, m_exp.lo);
      end
      if (frame_tick !== m_ft) begin
        errors++; $display("FAIL mon_frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, m_ft);
      end
    end
  end

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({an, seg_hi, seg_lo, frame_tick} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs got an=%h hi=%h lo=%h ft=%b exp all 0", an, seg_hi, seg_lo, frame_tick);
    end
  endtask

  task automatic test_first_frame();
    int tick_at;
    tick_at = -1;
    // H E 1 1 0 BLK BLK BLK, index 7 first
    seg_data_in  = {5'h10, 5'h0E, 5'h01, 5'h01, 5'h00, 5'h1F, 5'h1F, 5'h1F};
    seg_blink_in = 8'h00;
    disp_en      = 1'b1;
    rst          = 1'b0;
    mon_en       = 1'b1;
    for (int i = 0; i < 40 && tick_at < 0; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) tick_at = cyc;
    end
    checks++;
    if (tick_at !== 32) begin
      errors++; $display("FAIL first_tick got=%0d exp=32", tick_at);
    end
    repeat (35 - cyc) @(negedge clk);
    checks++;
    if ({an, seg_hi, seg_lo} !== {8'h88, 8'h76, 8'h3F}) begin
      errors++; $display("FAIL slot0 got an=%h hi=%h lo=%h exp 88 76 3f", an, seg_hi, seg_lo);
    end
    repeat (59 - cyc) @(negedge clk);
    checks++;
    if ({an, seg_hi, seg_lo} !== {8'h11, 8'h06, 8'h00}) begin
      errors++; $display("FAIL slot3 got an=%h hi=%h lo=%h exp 11 06 00", an, seg_hi, seg_lo);
    end
  endtask

  task automatic test_dead_time();
    int zeros [4];
    for (int s = 0; s < 4; s++) zeros[s] = 0;
    while (cyc % FR != 1) @(negedge clk);
    for (int i = 0; i < FR; i++) begin
      if (an == 8'h00) zeros[((cyc - 1) / SD) % 4]++;
      checks++;
      if ($countones(an) > 2) begin
        errors++; $display("FAIL an_bits cyc=%0d got=%h exp <=2 bits", cyc, an);
      end
      @(negedge clk);
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (zeros[s] != DC) begin
        errors++; $display("FAIL dead_cycles slot=%0d got=%0d exp=%0d", s, zeros[s], DC);
      end
    end
  endtask

  task automatic test_tearing();
    bit got_tick;
    got_tick = 0;
    seg_data_in = {8{5'h08}};
    seg_blink_in = 8'h00;
    for (int i = 0; i < 40 && !got_tick; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) got_tick = 1;
    end
    while (cyc % FR != 12) @(negedge clk);
    seg_data_in = {8{5'h01}};
    got_tick = 0;
    for (int i = 0; i < 40 && !got_tick; i++) begin
      @(negedge clk);
      if (an != 8'h00) begin
        checks++;
        if (seg_hi !== 8'h7F || seg_lo !== 8'h7F) begin
          errors++; $display("FAIL tear_old cyc=%0d got hi=%h lo=%h exp 7f", cyc, seg_hi, seg_lo);
        end
      end
      if (frame_tick === 1'b1) got_tick = 1;
    end
    checks++;
    if (!got_tick) begin
      errors++; $display("FAIL tear_tick got=none exp=frame_tick");
    end
    for (int i = 0; i < FR - 1; i++) begin
      @(negedge clk);
      if (an != 8'h00) begin
        checks++;
        if (seg_hi !== 8'h06 || seg_lo !== 8'h06) begin
          errors++; $display("FAIL tear_new cyc=%0d got hi=%h lo=%h exp 06", cyc, seg_hi, seg_lo);
        end
      end
    end
  endtask

  task automatic test_blink();
    bit got_tick, seen_on, seen_off;
    logic [7:0] want;
    got_tick = 0; seen_on = 0; seen_off = 0;
    for (int d = 0; d < 7; d++) seg_data_in[d] = 5'($urandom_range(0, 9));
    seg_data_in[7] = 5'h0C;
    seg_blink_in   = 8'h80;
    for (int i = 0; i < 40 && !got_tick; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) got_tick = 1;
    end
    for (int i = 0; i < 4 * BD; i++) begin
      @(negedge clk);
      if (an != 8'h00) begin
        checks++;
        if (seg_lo === 8'h00) begin
          errors++; $display("FAIL blink_steady_lo cyc=%0d got=00 exp nonzero", cyc);
        end
        if (((cyc - 1) / SD) % 4 == 0) begin
          want = (((cyc - 1) / BD) % 2 == 1) ? 8'h00 : 8'h39;
          if (seg_hi === 8'h39) seen_on = 1;
          if (seg_hi === 8'h00) seen_off = 1;
          checks++;
          if (seg_hi !== want) begin
            errors++; $display("FAIL blink_digit7 cyc=%0d got=%h exp=%h", cyc, seg_hi, want);
          end
        end
      end
    end
    checks++;
    if (!(seen_on && seen_off)) begin
      errors++; $display("FAIL blink_alternates got on=%0d off=%0d exp both", seen_on, seen_off);
    end
  endtask

  task automatic test_disp_en();
    bit back;
    back = 0;
    disp_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg_hi, seg_lo} !== 24'd0) begin
        errors++; $display("FAIL disp_off cyc=%0d got an=%h hi=%h lo=%h exp 0", cyc, an, seg_hi, seg_lo);
      end
    end
    disp_en = 1'b1;
    for (int i = 0; i < 12 && !back; i++) begin
      @(negedge clk);
      if (an != 8'h00) back = 1;
    end
    checks++;
    if (!back) begin
      errors++; $display("FAIL disp_resume got an=00 exp nonzero within 12 cycles");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        for (int d = 0; d < 8; d++) seg_data_in[d] = 5'($urandom_range(0, 31));
        seg_blink_in = 8'($urandom);
      end
      disp_en = ($urandom_range(0, 9) != 0);
    end
    @(negedge clk);
    disp_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    int tick_at;
    tick_at = -1;
    seg_data_in  = {8{5'h08}};
    seg_blink_in = 8'h00;
    while (cyc % FR != 2 * SD + 5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({an, seg_hi, seg_lo, frame_tick} !== 25'd0) begin
      errors++; $display("FAIL async_reset got an=%h hi=%h lo=%h ft=%b exp 0", an, seg_hi, seg_lo, frame_tick);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40 && tick_at < 0; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) tick_at = cyc;
      else begin
        checks++;
        if (seg_hi !== 8'h00 || seg_lo !== 8'h00) begin
          errors++; $display("FAIL blank_after_reset cyc=%0d got hi=%h lo=%h exp 00", cyc, seg_hi, seg_lo);
        end
      end
    end
    checks++;
    if (tick_at !== 32) begin
      errors++; $display("FAIL reset_tick got=%0d exp=32", tick_at);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_dead_time();
    test_tearing();
    test_blink();
    test_disp_en();
    test_random();
    test_mid_reset();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
